float_encoder: RTL and testbench

Sequential IEEE-754 packer, the inverse of the float field decoder in the conversions path. It accepts a sign, an unbiased signed exponent and an unnormalized wide mantissa over a valid/ready handshake. It normalizes, handles subnormals, rounds to nearest-even, and emits the packed `FSIZE`-bit float over a second valid/ready handshake. It sits at the output of the posit→float conversion datapath.

---
 rtl/float_encoder.sv | 120 ++++++++++++
 tb/tb_float_encoder.sv | 112 +++++++++++
 2 files changed

// File: rtl/float_encoder.sv
// float_encoder: sequential IEEE-754 packer (normalize, subnormal shift, round-to-nearest-even)
module float_encoder #(
  parameter int FSIZE     = 64,
  parameter int EXP_SIZE  = 11,
  parameter int MANT_SIZE = 52,
  parameter int MANT_IN   = 64
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sign,
  input  logic signed [EXP_SIZE+1:0]  in_exp,
  input  logic [MANT_IN-1:0]          in_mant,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FSIZE-1:0]            out_bits
);
  localparam int EXP_BIAS = 2 ** (EXP_SIZE - 1) - 1;
  localparam int EW = EXP_SIZE + $clog2(MANT_IN) + 2;
  localparam int CW = $clog2(MANT_IN + 3);
  localparam int RW = MANT_IN - MANT_SIZE - 2;
  localparam logic signed [EW-1:0] BIAS = EW'(EXP_BIAS);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_SIZE - 1);
  localparam logic [CW-1:0] CAP = CW'(MANT_IN + 2);

  typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, OUT} state_t;

  state_t                 state, state_n;
  logic                   sign, sign_n, sticky, sticky_n;
  logic signed [EW-1:0]   ex, ex_n, b, bf;
  logic [MANT_IN-1:0]     mant, mant_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [FSIZE-1:0]       bits_n, rbits;
  logic [MANT_SIZE:0]     kept, kr;
  logic [MANT_SIZE+1:0]   sum;
  logic                   guard, st, inc;

  assign in_ready  = state == IDLE;
  assign out_valid = state == OUT;

  // rounding datapath: kept/guard/sticky split, RNE increment, carry renormalization, inf clamp
  always_comb begin
    b     = ex + BIAS;
    kept  = mant[MANT_IN-1 -: MANT_SIZE+1];
    guard = mant[RW];
    st    = sticky | (|mant[RW-1:0]);
    inc   = guard & (st | kept[0]);
    sum   = {1'b0, kept} + (MANT_SIZE+2)'(inc);
    kr    = sum[MANT_SIZE+1] ? {1'b1, {MANT_SIZE{1'b0}}} : sum[MANT_SIZE:0];
    bf    = sum[MANT_SIZE+1] ? b + ONE : b;
    rbits = bf >= EMAX ? {sign, {EXP_SIZE{1'b1}}, {MANT_SIZE{1'b0}}}
                       : {sign, kr[MANT_SIZE] ? bf[EXP_SIZE-1:0] : {EXP_SIZE{1'b0}}, kr[MANT_SIZE-1:0]};
  end

  // next-state and next-datapath values
  always_comb begin
    state_n  = state;
    sign_n   = sign;
    ex_n     = ex;
    mant_n   = mant;
    sticky_n = sticky;
    cnt_n    = cnt;
    bits_n   = out_bits;
    case (state)
      IDLE: if (in_valid) begin
        sign_n   = in_sign;
        ex_n     = {{(EW-EXP_SIZE-2){in_exp[EXP_SIZE+1]}}, in_exp};
        mant_n   = in_mant;
        sticky_n = 1'b0;
        cnt_n    = '0;
        state_n  = NORM;
      end
      NORM: if (mant == '0) begin
        bits_n  = {sign, {(FSIZE-1){1'b0}}};
        state_n = OUT;
      end else if (mant[MANT_IN-1]) begin
        state_n = b < ONE ? DENORM : ROUND;
      end else begin
        mant_n = mant << 1;
        ex_n   = ex - ONE;
      end
      DENORM: begin
        mant_n   = mant >> 1;
        sticky_n = sticky | mant[0];
        ex_n     = ex + ONE;
        cnt_n    = cnt + CW'(1);
        state_n  = (~|b || cnt_n == CAP) ? ROUND : DENORM;
      end
      ROUND: begin
        bits_n  = rbits;
        state_n = OUT;
      end
      OUT: state_n = out_ready ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end

  // state and datapath registers, cleared by asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sign     <= 1'b0;
      ex       <= '0;
      mant     <= '0;
      sticky   <= 1'b0;
      cnt      <= '0;
      out_bits <= '0;
    end else begin
      state    <= state_n;
      sign     <= sign_n;
      ex       <= ex_n;
      mant     <= mant_n;
      sticky   <= sticky_n;
      cnt      <= cnt_n;
      out_bits <= bits_n;
    end
  end
endmodule

// File: tb/tb_float_encoder.sv
// tb_float_encoder: directed vectors for the float packer, latency and handshake checks
module tb_float_encoder;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_sign = 1'b0;
  logic signed [12:0] in_exp = '0;
  logic [63:0]        in_mant = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [63:0]        out_bits;
  int                 nvec = 0;
  int                 nbad = 0;

  float_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic send(input logic s, input logic signed [12:0] e, input logic [63:0] m);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic signed [12:0] e,
                     input logic [63:0] m, input logic [63:0] want, input int lat);
    int n;
    send(s, e, m);
    wait_out(n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check(tag, out_bits, want);
    @(posedge clk);
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bits", out_bits, 64'd0);
    @(negedge clk) rst = 1'b0;
    run("normal",    1'b0, 13'(6),     64'hF700_0000_0000_0000, 64'h405E_E000_0000_0000, 2);
    run("norm_one",  1'b0, 13'(63),    64'h1,                   64'h3FF0_0000_0000_0000, 65);
    run("neg_zero",  1'b1, 13'(0),     64'h0,                   64'h8000_0000_0000_0000, 1);
    run("rne_odd",   1'b0, 13'(0),     64'hFFFF_FFFF_FFFF_FC00, 64'h4000_0000_0000_0000, 2);
    run("rne_even",  1'b0, 13'(0),     64'hFFFF_FFFF_FFFF_F400, 64'h3FFF_FFFF_FFFF_FFFE, 2);
    run("ovf_neg",   1'b1, 13'(1024),  64'h8000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 2);
    run("ovf_round", 1'b0, 13'(1023),  64'hFFFF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000, 2);
    run("sub_min",   1'b0, 13'(-1074), 64'h8000_0000_0000_0000, 64'h1, 54);
    run("sub_up",    1'b0, 13'(-1075), 64'hC000_0000_0000_0000, 64'h1, 55);
    run("sub_tie",   1'b0, 13'(-1075), 64'h8000_0000_0000_0000, 64'h0, 55);
    run("sub_cap",   1'b0, 13'(-1200), 64'h8000_0000_0000_0000, 64'h0, 68);
    run("sub_carry", 1'b0, 13'(-1023), 64'hFFFF_FFFF_FFFF_FFFF, 64'h0010_0000_0000_0000, 3);
    out_ready = 1'b0;
    send(1'b0, 13'(6), 64'hF700_0000_0000_0000);
    wait_out(n);
    check("hold_lat", 64'(n), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mant  = 64'h8000_0000_0000_0000;
      @(posedge clk);
      #1 check("hold_bits", out_bits, 64'h405E_E000_0000_0000);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready), 64'd1);
    run("after_hold", 1'b1, 13'(0), 64'h8000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 2);
    send(1'b0, 13'(63), 64'h1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort_no_out", 64'(out_valid), 64'd0);
    run("post_reset", 1'b0, 13'(6), 64'hF700_0000_0000_0000, 64'h405E_E000_0000_0000, 2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
